// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit bit engine.
// Line levels are packed as {dp, dm}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } state_e;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [1:0] EOP_SE0_BITS = 2'd2;

  // NRZI: a 0 toggles J<->K, a 1 holds the current level.
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
    if (bit_val) begin
      return line;
    end else begin
      return (line == LINE_J) ? LINE_K : LINE_J;
    end
  endfunction

endpackage

// File: rtl/bit_pd_counter_tx.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// final cycle of each bit period.
module bit_pd_counter_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic bit_strobe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_strobe = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/usb_tx_bit_encoder.sv
// USB full-speed transmit bit engine: SYNC, LSB-first serialisation, bit
// stuffing, NRZI and EOP onto registered D+/D- with output enable.
module usb_tx_bit_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        last_cur_q, last_cur_d;
  logic [2:0]  ones_q, ones_d;
  logic [1:0]  eop_cnt_q, eop_cnt_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_last_q, hold_last_d;
  logic        hold_valid_q, hold_valid_d;
  logic [1:0]  line_q, line_d;
  logic        oe_q, oe_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        strobe_s;
  logic        accept_s;
  logic        hold_full_s;
  logic [7:0]  hold_byte_s;
  logic        hold_last_s;
  logic        data_bit_s;

  bit_pd_counter_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_pd (
    .clk        (clk),
    .rst        (rst),
    .enable     (state_q != ST_IDLE),
    .clear      (state_q == ST_IDLE),
    .bit_strobe (strobe_s)
  );

  // FSM, shifter, stuffer, NRZI and holding register next-state
  always_comb begin
    accept_s     = tx_valid && ready_q;
    // a byte arriving on the boundary cycle is loaded straight into the shifter
    hold_full_s  = hold_valid_q || accept_s;
    hold_byte_s  = hold_valid_q ? hold_data_q : tx_data;
    hold_last_s  = hold_valid_q ? hold_last_q : tx_last;
    data_bit_s   = shift_q[bit_idx_q + 3'd1];

    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    last_cur_d   = last_cur_q;
    ones_d       = ones_q;
    eop_cnt_d    = eop_cnt_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    line_d       = line_q;
    oe_d         = oe_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    if (accept_s) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
      hold_last_d  = tx_last;
    end else begin
      hold_valid_d = hold_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        ones_d = 3'd0;
        line_d = LINE_J;
        oe_d   = 1'b0;
        if (tx_start) begin
          state_d    = ST_SYNC;
          shift_d    = SYNC_BYTE;
          bit_idx_d  = 3'd0;
          last_cur_d = 1'b0;
          line_d     = nrzi_next(LINE_J, SYNC_BYTE[0]);
          ones_d     = {2'b00, SYNC_BYTE[0]};
          oe_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (!strobe_s) begin
          state_d = state_q;
        end else if (ones_q == STUFF_LIMIT) begin
          line_d = nrzi_next(line_q, 1'b0);
          ones_d = 3'd0;
        end else if (bit_idx_q != 3'd7) begin
          bit_idx_d = bit_idx_q + 3'd1;
          line_d    = nrzi_next(line_q, data_bit_s);
          ones_d    = data_bit_s ? (ones_q + 3'd1) : 3'd0;
        end else if (hold_full_s) begin
          state_d      = ST_DATA;
          shift_d      = hold_byte_s;
          last_cur_d   = hold_last_s;
          bit_idx_d    = 3'd0;
          hold_valid_d = 1'b0;
          line_d       = nrzi_next(line_q, hold_byte_s[0]);
          ones_d       = hold_byte_s[0] ? (ones_q + 3'd1) : 3'd0;
        end else begin
          // no next byte: end the packet, flagging underrun unless it was last
          state_d   = ST_EOP_SE0;
          eop_cnt_d = 2'd0;
          line_d    = LINE_SE0;
          err_d     = !last_cur_q;
        end
      end
      ST_EOP_SE0: begin
        if (!strobe_s) begin
          state_d = ST_EOP_SE0;
        end else if (eop_cnt_q == (EOP_SE0_BITS - 2'd1)) begin
          state_d = ST_EOP_J;
          line_d  = LINE_J;
        end else begin
          eop_cnt_d = eop_cnt_q + 2'd1;
        end
      end
      ST_EOP_J: begin
        if (strobe_s) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          ones_d  = 3'd0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_EOP_J;
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = LINE_J;
        oe_d    = 1'b0;
      end
    endcase

    ready_d = !hold_valid_d &&
              ((state_d == ST_IDLE) || (state_d == ST_SYNC) || (state_d == ST_DATA));
    busy_d  = (state_d != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'h00;
      bit_idx_q    <= 3'd0;
      last_cur_q   <= 1'b0;
      ones_q       <= 3'd0;
      eop_cnt_q    <= 2'd0;
      hold_data_q  <= 8'h00;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      line_q       <= LINE_J;
      oe_q         <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      last_cur_q   <= last_cur_d;
      ones_q       <= ones_d;
      eop_cnt_q    <= eop_cnt_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      line_q       <= line_d;
      oe_q         <= oe_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign tx_ready = ready_q;
  assign dp_out   = line_q[1];
  assign dm_out   = line_q[0];
  assign tx_oe    = oe_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_err   = err_q;

endmodule
